// File: rtl/sr_pkg.sv
// Shared types and constants for the SR latch command encoder.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } sr_enc_state_t;

  localparam logic SR_LVL_SET = 1'b1;
  localparam logic SR_LVL_RST = 1'b0;

endpackage

// File: rtl/sr_tick_counter.sv
// Loadable down-counter that times both the pulse and the idle gap.
module sr_tick_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load wins over decrement; the count holds at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign count = r_cnt;
  assign zero  = (r_cnt == '0);

endmodule

// File: rtl/sr_cmd_encoder.sv
// Turns requested latch levels into shaped, non-overlapping s/r pulses.
// Optional readback checking is built when SR_ENC_CHECK_EN is defined.
module sr_cmd_encoder
  import sr_pkg::*;
#(
  parameter int PULSE_W = 1,
  parameter int GAP_W   = 1,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic s,
  output logic r,
  output logic q_model,
  output logic busy
`ifdef SR_ENC_CHECK_EN
  ,
  input  logic q_fb,
  output logic mismatch
`endif
);

  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'((GAP_W > 0) ? (GAP_W - 1) : 0);
  localparam bit GAP_NONE = (GAP_W == 0);
  localparam bit ONE_SHOT = (PULSE_W == 1) && (GAP_W == 0);

  sr_enc_state_t    r_state;
  logic             r_s;
  logic             r_r;
  logic             r_q;
  logic             r_ready;

  logic             w_change;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_dec;
  logic             w_zero;
  logic [CNT_W-1:0] w_cnt;

  // Only acceptances that actually flip the modelled level start a pulse.
  assign w_change = req_valid & r_ready & (req_level != r_q);

  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_change) begin
          w_load     = 1'b1;
          w_load_val = LD_PULSE;
        end
      end
      PULSE: begin
        if (!w_zero) begin
          w_dec = 1'b1;
        end else if (!GAP_NONE) begin
          w_load     = 1'b1;
          w_load_val = LD_GAP;
        end else if (w_change) begin
          w_load     = 1'b1;
          w_load_val = LD_PULSE;
        end
      end
      GAP: begin
        w_dec = 1'b1;
      end
      default: begin
      end
    endcase
  end

  sr_tick_counter #(
    .CNT_W(CNT_W)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .load_val(w_load_val),
    .dec     (w_dec),
    .count   (w_cnt),
    .zero    (w_zero)
  );

  // With no gap, ready is raised in the last pulse cycle so a new level
  // change can start on the very edge that ends the current pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_q     <= SR_LVL_RST;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_change) begin
            r_state <= PULSE;
            r_s     <= (req_level == SR_LVL_SET);
            r_r     <= (req_level == SR_LVL_RST);
            r_q     <= req_level;
            r_ready <= ONE_SHOT;
          end
        end
        PULSE: begin
          if (w_zero) begin
            r_s <= 1'b0;
            r_r <= 1'b0;
            if (!GAP_NONE) begin
              r_state <= GAP;
              r_ready <= 1'b0;
            end else if (w_change) begin
              r_state <= PULSE;
              r_s     <= (req_level == SR_LVL_SET);
              r_r     <= (req_level == SR_LVL_RST);
              r_q     <= req_level;
              r_ready <= ONE_SHOT;
            end else begin
              r_state <= IDLE;
              r_ready <= 1'b1;
            end
          end else begin
            r_ready <= GAP_NONE && (w_cnt == CNT_W'(1));
          end
        end
        GAP: begin
          if (w_zero) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign s         = r_s;
  assign r         = r_r;
  assign q_model   = r_q;
  assign busy      = (r_state != IDLE);

`ifdef SR_ENC_CHECK_EN
  logic r_prev_busy;
  logic r_mismatch;

  // The first idle cycle after any pulse/gap is skipped so the latch can settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_busy <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      r_prev_busy <= (r_state != IDLE);
      if ((r_state == IDLE) && !r_prev_busy && (q_fb != r_q)) begin
        r_mismatch <= 1'b1;
      end
    end
  end

  assign mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_sr_cmd_encoder.sv
// Bench for sr_cmd_encoder: two instances (PULSE_W=2/GAP_W=1 and PULSE_W=1/GAP_W=0)
// checked against a timeline model of pulse windows derived from acceptance times.
module tb_sr_cmd_encoder;

  localparam int PA = 2;
  localparam int GA = 1;
  localparam int PB = 1;
  localparam int GB = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic va = 1'b0, la = 1'b0, vb = 1'b0, lb = 1'b0;
  logic rdy_a, s_a, r_a, q_a, busy_a;
  logic rdy_b, s_b, r_b, q_b, busy_b;

`ifdef SR_ENC_CHECK_EN
  logic fb_force = 1'b0;
  logic fb_a, fb_b, mis_a, mis_b;
  assign fb_a = fb_force ? 1'b0 : q_a;
  assign fb_b = q_b;
`endif

  sr_cmd_encoder #(.PULSE_W(PA), .GAP_W(GA), .CNT_W(8)) dut_a (
    .clk(clk), .reset(rst), .req_valid(va), .req_level(la), .req_ready(rdy_a),
    .s(s_a), .r(r_a), .q_model(q_a), .busy(busy_a)
`ifdef SR_ENC_CHECK_EN
    , .q_fb(fb_a), .mismatch(mis_a)
`endif
  );

  sr_cmd_encoder #(.PULSE_W(PB), .GAP_W(GB), .CNT_W(8)) dut_b (
    .clk(clk), .reset(rst), .req_valid(vb), .req_level(lb), .req_ready(rdy_b),
    .s(s_b), .r(r_b), .q_model(q_b), .busy(busy_b)
`ifdef SR_ENC_CHECK_EN
    , .q_fb(fb_b), .mismatch(mis_b)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: each level change opens a window of P cycles of s/r
  // followed by G quiet cycles, measured from the acceptance edge.
  int   mp[2] = '{PA, PB};
  int   mg[2] = '{GA, GB};
  int   k = 0;
  int   t0[2] = '{-1000, -1000};
  logic mq[2] = '{1'b0, 1'b0};
  logic mlvl[2] = '{1'b0, 1'b0};
  logic eready[2] = '{1'b0, 1'b0};
  logic es[2] = '{1'b0, 1'b0};
  logic er[2] = '{1'b0, 1'b0};
  logic ebusy[2] = '{1'b0, 1'b0};
  logic emis[2] = '{1'b0, 1'b0};
  logic mprev[2] = '{1'b0, 1'b0};

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic v, l, fbv;
      int d;
      v = (i == 0) ? va : vb;
      l = (i == 0) ? la : lb;
      fbv = mq[i];
`ifdef SR_ENC_CHECK_EN
      if (i == 0 && fb_force) fbv = 1'b0;
`endif
      if (rst) emis[i] = 1'b0;
      else if (!ebusy[i] && !mprev[i] && (fbv != mq[i])) emis[i] = 1'b1;
      mprev[i] = rst ? 1'b0 : ebusy[i];
      if (rst) begin
        mq[i] = 1'b0;
        t0[i] = -1000;
      end else if (v && eready[i] && (l != mq[i])) begin
        t0[i] = k;
        mlvl[i] = l;
        mq[i] = l;
      end
      d = k - t0[i];
      es[i] = (d < mp[i]) && mlvl[i];
      er[i] = (d < mp[i]) && !mlvl[i];
      ebusy[i] = (d < mp[i] + mg[i]);
      eready[i] = !rst && (!ebusy[i] || (mg[i] == 0 && d == mp[i] - 1));
    end
    k++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag);
    chk1({tag, "_a_s"}, s_a, es[0]);
    chk1({tag, "_a_r"}, r_a, er[0]);
    chk1({tag, "_a_q"}, q_a, mq[0]);
    chk1({tag, "_a_busy"}, busy_a, ebusy[0]);
    chk1({tag, "_a_ready"}, rdy_a, eready[0]);
    chk1({tag, "_a_s_and_r"}, s_a & r_a, 1'b0);
    chk1({tag, "_b_s"}, s_b, es[1]);
    chk1({tag, "_b_r"}, r_b, er[1]);
    chk1({tag, "_b_q"}, q_b, mq[1]);
    chk1({tag, "_b_busy"}, busy_b, ebusy[1]);
    chk1({tag, "_b_ready"}, rdy_b, eready[1]);
    chk1({tag, "_b_s_and_r"}, s_b & r_b, 1'b0);
`ifdef SR_ENC_CHECK_EN
    chk1({tag, "_a_mismatch"}, mis_a, emis[0]);
    chk1({tag, "_b_mismatch"}, mis_b, emis[1]);
`endif
  endtask

  initial begin
    @(negedge clk);
    // Reset state, then release.
    rst = 1'b1;
    step(); chk("reset0");
    va = 1'b1; la = 1'b1; vb = 1'b1; lb = 1'b1;
    step(); chk("reset_valid");
    va = 1'b0; vb = 1'b0;
    rst = 1'b0;
    step(); chk("release");

    // Set request on A: two-cycle s pulse, one gap cycle.
    va = 1'b1; la = 1'b1;
    step(); chk("a_set_accept");
    va = 1'b0;
    repeat (4) begin step(); chk("a_set_run"); end

    // Redundant requests back-to-back.
    va = 1'b1; la = 1'b1;
    repeat (4) begin step(); chk("a_redundant"); end
    va = 1'b0;

    // Alternating levels on B with valid held.
    vb = 1'b1; lb = 1'b1; step(); chk("b_alt_s");
    lb = 1'b0; step(); chk("b_alt_r");
    lb = 1'b1; step(); chk("b_alt_s2");
    vb = 1'b0; step(); chk("b_alt_end");

    // Reset during A's second pulse cycle.
    va = 1'b1; la = 1'b0;
    step(); chk("a_rst_pulse0");
    va = 1'b0;
    step(); chk("a_rst_pulse1");
    rst = 1'b1;
    step(); chk("a_rst_mid");
    rst = 1'b0;
    step(); chk("a_rst_after0");
    step(); chk("a_rst_after1");

    // Request held through the gap is taken once idle.
    va = 1'b1; la = 1'b1;
    step(); chk("a_hold_accept");
    la = 1'b0;
    repeat (6) begin step(); chk("a_hold_run"); end
    va = 1'b0;
    repeat (3) begin step(); chk("a_hold_drain"); end

`ifdef SR_ENC_CHECK_EN
    // Readback forced low while the model says set.
    va = 1'b1; la = 1'b1;
    step(); chk("fb_set");
    va = 1'b0;
    repeat (4) begin step(); chk("fb_settle"); end
    fb_force = 1'b1;
    repeat (3) begin step(); chk("fb_forced"); end
    fb_force = 1'b0;
    repeat (2) begin step(); chk("fb_sticky"); end
    rst = 1'b1;
    step(); chk("fb_reset");
    rst = 1'b0;
    step(); chk("fb_cleared");
`endif

    // Randomised traffic with occasional resets.
    repeat (400) begin
      rst = ($urandom_range(0, 39) == 0);
      va  = 1'($urandom_range(0, 1));
      la  = 1'($urandom_range(0, 1));
      vb  = 1'($urandom_range(0, 1));
      lb  = 1'($urandom_range(0, 1));
      step(); chk("rnd");
    end
    rst = 1'b0; va = 1'b0; vb = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_cmd_encoder.md
# sr_cmd_encoder

Drive-side companion to the SR latch: converts a stream of requested output levels into properly shaped set/reset pulses on the latch's `s`/`r` inputs. Keeps a model of the latch state, drops requests that would not change it, and never asserts `s` and `r` together. It also enforces a programmable pulse width and a minimum idle gap between pulses. It sits between control logic (valid/ready request port) and one `sr_latch` instance.

## Interface
- `PULSE_W`, 1: cycles `s` or `r` is held high per command. Legal range is at least 1.
- `GAP_W`, 1: minimum cycles with `s=r=0` after each pulse before the next request is accepted. Legal range is at least 0.
- `CNT_W`, 8: width of the internal cycle counter. Must hold `max(PULSE_W, GAP_W)`.
- `clk`  in  1  single clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_level`  in  1  requested latch level: 1 means set, 0 means reset.
- `req_ready`  out  1  encoder can accept a request this cycle.
- `s`  out  1  latch set drive, registered.
- `r`  out  1  latch reset drive, registered.
- `q_model`  out  1  modelled latch state, registered.
- `busy`  out  1  a pulse or gap is in progress.
- `q_fb`  in  1  latch `q` readback. Present only with `SR_ENC_CHECK_EN`.
- `mismatch`  out  1  sticky readback error. Present only with `SR_ENC_CHECK_EN`.

## Operation
- FSM has three states.
  - IDLE: `req_ready=1`.
  - PULSE: drives `s` or `r`.
  - GAP: `s=r=0`, `req_ready=0`.
- Handshake: a request is accepted on an edge where `req_valid & req_ready` are both high. `req_level` is sampled only at acceptance.
- Accepted request with `req_level == q_model` is redundant.
  - It is consumed with no pulse; the FSM stays in IDLE.
  - `req_ready` stays 1, so back-to-back redundant requests are accepted every cycle.
- Accepted request with `req_level != q_model`:
  - The FSM enters PULSE.
  - `s` is driven when `req_level=1`, otherwise `r` is driven.
  - `q_model` takes `req_level` on the same edge.
  - The counter loads `PULSE_W-1`.
- PULSE: the counter decrements each cycle. At 0, the FSM goes to GAP (counter loads `GAP_W-1`). If `GAP_W=0`, it goes to IDLE instead.
- GAP: the counter decrements each cycle. At 0, the FSM goes to IDLE.
- `busy` = state != IDLE.
- Invariant: `s & r` is never 1 on any cycle. Both `s` and `r` are deasserted whenever leaving PULSE.
- `req_valid` while not ready is ignored. The requester must hold the request until it is accepted.

## Timing
- Reset values:
  - `s=0`, `r=0`, `q_model=0`, `busy=0`.
  - `req_ready=0` while `reset` is high; it becomes 1 on the first edge with `reset` low.
  - `mismatch=0`.
  - State is IDLE and the counter is 0.
- Latency: request accepted at edge E0. `s`/`r` is high from just after E0 through edge E`PULSE_W`.
- `req_ready` is low for exactly `PULSE_W+GAP_W` cycles after a non-redundant acceptance.
- Throughput: one level change per `PULSE_W+GAP_W` cycles. With `PULSE_W=1`, `GAP_W=0`, this is one change every cycle, with alternating `s`/`r` possible.
- Reset mid-PULSE or mid-GAP: on the next edge, `s`/`r` drop to 0, `q_model` goes to 0, and the FSM returns to IDLE. The in-flight request is lost.
- `req_valid` asserted during the reset cycle is not accepted.

## Configuration
- `SR_ENC_CHECK_EN` defined:
  - Adds `q_fb` and `mismatch`.
  - In IDLE only, `q_fb` is sampled each cycle and compared with `q_model`.
  - On inequality, `mismatch` is set on the next edge. It is sticky and cleared only by `reset`.
  - Comparison is suppressed on the first IDLE cycle after GAP, to allow settling.
- `SR_ENC_CHECK_EN` undefined: neither port exists and no compare logic is built. All other behaviour is identical.

## Structure
- Shared package `sr_pkg`:
  - State enum `sr_enc_state_t` (IDLE, PULSE, GAP).
  - Level constants `SR_LVL_SET=1'b1`, `SR_LVL_RST=1'b0`.
- Sub-module `sr_tick_counter`: loadable down-counter of width `CNT_W`, with `load`, `dec`, and `zero` outputs. Used for both pulse and gap timing.

## Test plan
- Reset, then `req_level=1` with `PULSE_W=2`, `GAP_W=1`: `s` is high for 2 cycles, `r` stays 0, `q_model=1`, and `req_ready` returns after 3 cycles.
- From `q_model=1`, send `req_level=1` four cycles back-to-back: no pulses, `req_ready` stays 1, `q_model` stays 1.
- Alternate 1,0,1 with `PULSE_W=1`, `GAP_W=0`, `req_valid` held: the sequence is `s`,`r`,`s` on consecutive cycles, and `s&r` is never 1.
- Assert `reset` during the second PULSE cycle: `s=0` and `q_model=0` on the next edge, `req_ready=1` one cycle after `reset` falls.
- `req_valid` asserted during GAP: not accepted until IDLE; the held request is then accepted on the first IDLE edge.
- With `SR_ENC_CHECK_EN`, force `q_fb=0` while `q_model=1` in IDLE: `mismatch` goes to 1 and stays 1 until `reset`.
